// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter and fetch sequencer with OUTPUT handshake and HALT hold
// Selects the next PC from jr/jump/branch decode and stalls the core in OUT_WAIT or HALTED.
module pc_sequencer #(
    parameter int                     PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0]    RESET_PC = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  jump,
    input  logic                  branch,
    input  logic                  branch_cond,
    input  logic                  jr,
    input  logic                  halt,
    input  logic                  output_flag,
    input  logic [15:0]           br_offset,
    input  logic [25:0]           j_index,
    input  logic [PC_WIDTH-1:0]   jr_target,
    input  logic                  out_ack,
    input  logic                  resume,
    output logic [PC_WIDTH-1:0]   pc,
    output logic [PC_WIDTH-1:0]   pc_plus1,
    output logic                  out_valid,
    output logic                  stall,
    output logic                  halted
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_OUT_WAIT = 2'd1,
        ST_HALTED   = 2'd2
    } state_t;

    state_t                r_state;
    logic [PC_WIDTH-1:0]   r_pc;
    logic                  r_out_valid;
    logic                  r_stall;
    logic                  r_halted;

    state_t                w_next_state;
    logic [PC_WIDTH-1:0]   w_next_pc;
    logic [PC_WIDTH-1:0]   w_pc_plus1;
    logic [PC_WIDTH-1:0]   w_br_off;
    logic [PC_WIDTH-1:0]   w_j_target;
    logic [PC_WIDTH-1:0]   w_br_target;

    // Immediates are fitted to PC_WIDTH: sign-extend the offset, zero-extend the index, truncate if narrower.
    generate
        if (PC_WIDTH > 16) begin : g_off_ext
            assign w_br_off = {{(PC_WIDTH-16){br_offset[15]}}, br_offset};
        end else begin : g_off_trunc
            assign w_br_off = br_offset[PC_WIDTH-1:0];
        end
        if (PC_WIDTH > 26) begin : g_jidx_ext
            assign w_j_target = {{(PC_WIDTH-26){1'b0}}, j_index};
        end else begin : g_jidx_trunc
            assign w_j_target = j_index[PC_WIDTH-1:0];
        end
    endgenerate

    assign w_pc_plus1  = r_pc + {{(PC_WIDTH-1){1'b0}}, 1'b1};
    assign w_br_target = w_pc_plus1 + w_br_off;

    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        case (r_state)
            ST_RUN: begin
                if (halt) begin
                    w_next_state = ST_HALTED;
                end else if (output_flag) begin
                    w_next_state = ST_OUT_WAIT;
                end else if (jr) begin
                    w_next_pc = jr_target;
                end else if (jump) begin
                    w_next_pc = w_j_target;
                end else if (branch && branch_cond) begin
                    w_next_pc = w_br_target;
                end else begin
                    w_next_pc = w_pc_plus1;
                end
            end
            ST_OUT_WAIT: begin
                if (out_ack) begin
                    w_next_state = ST_RUN;
                    w_next_pc    = w_pc_plus1;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    w_next_state = ST_RUN;
                    w_next_pc    = w_pc_plus1;
                end
            end
            default: begin
                w_next_state = ST_RUN;
            end
        endcase
    end

    // Status flags are registered alongside the state so they always match it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RUN;
            r_pc        <= RESET_PC;
            r_out_valid <= 1'b0;
            r_stall     <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_pc        <= w_next_pc;
            r_out_valid <= (w_next_state == ST_OUT_WAIT);
            r_stall     <= (w_next_state != ST_RUN);
            r_halted    <= (w_next_state == ST_HALTED);
        end
    end

    assign pc        = r_pc;
    assign pc_plus1  = w_pc_plus1;
    assign out_valid = r_out_valid;
    assign stall     = r_stall;
    assign halted    = r_halted;

endmodule
